// File: rtl/sata_fifo_pkg.sv
// Shared types for the SATA ping-pong FIFO controllers: the reader FSM state
// encoding and the round-robin priority search used by read and write sides.
package sata_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      XFER,
      RELEASE
   } rr_state_t;

   localparam int unsigned RR_MAX_CH = 8;
   localparam int unsigned RR_IDX_W  = 3;

   typedef struct packed {
      logic                valid;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First ready channel strictly after last_grant, wrapping modulo num_ch.
   function automatic rr_pick_t rr_next(input logic [RR_MAX_CH-1:0] ready_vec,
                                        input logic [RR_IDX_W-1:0]  last_grant,
                                        input int unsigned          num_ch);
      rr_pick_t            pick;
      logic [RR_IDX_W-1:0] idx;
      pick = '0;
      for (int unsigned k = 1; k <= RR_MAX_CH; k++) begin
         idx = RR_IDX_W'((32'(last_grant) + k) % num_ch);
         if (k <= num_ch && !pick.valid && ready_vec[idx]) begin
            pick.valid = 1'b1;
            pick.idx   = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the next ready channel after
// last_grant. Shared by the read- and write-side ping-pong FIFO controllers.
module rr_pick
   import sata_fifo_pkg::*;
#(
   parameter int NUM_CH = 2,
   localparam int IDX_W = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] ready_vec,
   input  logic [IDX_W-1:0]  last_grant,
   output logic              valid,
   output logic [IDX_W-1:0]  idx
);

   rr_pick_t pick;

   always_comb begin
      pick  = rr_next(RR_MAX_CH'(ready_vec), RR_IDX_W'(last_grant), NUM_CH);
      valid = pick.valid;
      idx   = pick.idx[IDX_W-1:0];
   end

endmodule

// File: rtl/ppfifo_rr_reader.sv
// Round-robin read controller draining NUM_CH ping-pong FIFOs into one registered
// valid/ready stream. Define PPFIFO_RR_READER_STATS_EN to add per-channel burst counters.
module ppfifo_rr_reader
   import sata_fifo_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 32,
   parameter int SIZE_WIDTH = 24,
   localparam int CH_W      = $clog2(NUM_CH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic [NUM_CH-1:0]              ch_ready,
   output logic [NUM_CH-1:0]              ch_activate,
   input  logic [NUM_CH*SIZE_WIDTH-1:0]   ch_size,
   output logic [NUM_CH-1:0]              ch_strobe,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic [CH_W-1:0]                out_channel,
   output logic                           out_last,
   output logic                           busy
`ifdef PPFIFO_RR_READER_STATS_EN
   ,
   output logic [NUM_CH*16-1:0]           stat_bursts
`endif
);

   rr_state_t             state_q, state_d;
   logic [CH_W-1:0]       grant_q, grant_d;
   logic [CH_W-1:0]       last_grant_q, last_grant_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic [SIZE_WIDTH-1:0] count_q, count_d, count_inc;
   logic [NUM_CH-1:0]     activate_q, activate_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CH_W-1:0]       out_channel_q, out_channel_d;

   logic                  pick_valid;
   logic [CH_W-1:0]       pick_idx;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [SIZE_WIDTH-1:0] sel_size;
   logic                  strobe;

   rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .ready_vec  (ch_ready),
      .last_grant (last_grant_q),
      .valid      (pick_valid),
      .idx        (pick_idx)
   );

   always_comb begin
      sel_data = '0;
      sel_size = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant_q == CH_W'(c))  sel_data = ch_data[c*DATA_WIDTH +: DATA_WIDTH];
         if (pick_idx == CH_W'(c)) sel_size = ch_size[c*SIZE_WIDTH +: SIZE_WIDTH];
      end
   end

   assign count_inc = count_q + 1'b1;
   // A word leaves the FIFO only when the output register is free or emptying this cycle.
   assign strobe    = (state_q == XFER) && (count_q < size_q) && (!out_valid_q || out_ready);

   always_comb begin
      // NOTE: every *_d and combinational output is defaulted first, so no branch infers a latch.
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      size_d        = size_q;
      count_d       = count_q;
      activate_d    = activate_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_channel_d = out_channel_q;
      out_last_d    = out_last_q;
      ch_strobe     = '0;

      case (state_q)
         IDLE: begin
            if (enable && pick_valid) begin
               grant_d = pick_idx;
               size_d  = sel_size;
               count_d = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            activate_d = NUM_CH'(1) << grant_q;
            state_d    = XFER;
         end
         XFER: begin
            if (count_q == size_q) begin
               activate_d   = '0;
               last_grant_d = grant_q;
               state_d      = RELEASE;
            end else if (strobe) begin
               ch_strobe = NUM_CH'(1) << grant_q;
               count_d   = count_inc;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (strobe) begin
         out_valid_d   = 1'b1;
         out_data_d    = sel_data;
         out_channel_d = grant_q;
         out_last_d    = (count_inc == size_q);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         last_grant_q  <= CH_W'(NUM_CH - 1);
         size_q        <= '0;
         count_q       <= '0;
         activate_q    <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_channel_q <= '0;
         out_last_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         size_q        <= size_d;
         count_q       <= count_d;
         activate_q    <= activate_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_channel_q <= out_channel_d;
         out_last_q    <= out_last_d;
      end
   end

   assign ch_activate = activate_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_channel = out_channel_q;
   assign out_last    = out_last_q;
   assign busy        = (state_q != IDLE) || out_valid_q;

`ifdef PPFIFO_RR_READER_STATS_EN
   logic [NUM_CH*16-1:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (state_q == XFER && count_q == size_q && grant_q == CH_W'(c))
            stat_d[c*16 +: 16] = stat_q[c*16 +: 16] + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stat_q <= '0;
      else     stat_q <= stat_d;
   end

   assign stat_bursts = stat_q;
`endif

endmodule

// File: tb/tb_ppfifo_rr_reader.sv
// Bench for ppfifo_rr_reader: bench-side FIFO channels, a grant/stream model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_ppfifo_rr_reader;

   localparam int NUM_CH = 2;
   localparam int DW     = 32;
   localparam int SW     = 24;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            enable = 1'b1;
   logic            out_ready = 1'b1;
   logic [1:0]      ch_ready = '0;
   logic [1:0]      ch_activate, ch_strobe;
   logic [2*SW-1:0] ch_size;
   logic [2*DW-1:0] ch_data;
   logic            out_valid, out_last, busy;
   logic [DW-1:0]   out_data;
   logic [0:0]      out_channel;

   int unsigned     size_cfg [2] = '{4, 4};
   logic [27:0]     ptr [2] = '{28'd0, 28'd0};
   logic [1:0]      strobe_pend = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign ch_size = {SW'(size_cfg[1]), SW'(size_cfg[0])};
   assign ch_data = {4'hB, ptr[1], 4'hA, ptr[0]};

   ppfifo_rr_reader #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .ch_ready    (ch_ready),
      .ch_activate (ch_activate),
      .ch_size     (ch_size),
      .ch_strobe   (ch_strobe),
      .ch_data     (ch_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_channel (out_channel),
      .out_last    (out_last),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic logic [1:0] onehot(input int c);
      return 2'b01 << c;
   endfunction

   function automatic logic [DW-1:0] word_of(input int c, input logic [27:0] p);
      return {4'hA + 4'(c), p};
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   typedef struct {
      logic [DW-1:0] d;
      int            ch;
      bit            last;
   } word_t;

   word_t         expq[$];
   logic [DW-1:0] acc_log[$];
   bit            acc_last_log[$];
   int            grant_log[$];

   int            cyc = 0;
   int            idle_from = 0;
   int            pend = -1;
   int            exp_ch = 0;
   int            exp_size = 0;
   int            strobe_cnt = 0;
   int            model_last = NUM_CH - 1;
   bit            burst = 0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data;
   logic [0:0]    prev_ch;
   logic          prev_last;

   always @(negedge clk) begin
      word_t w;
      cyc++;
      if (rst) begin
         expq.delete();
         burst      = 0;
         pend       = -1;
         model_last = NUM_CH - 1;
         idle_from  = cyc + 1;
         prev_stall = 0;
         check("reset_outputs", {ch_activate, ch_strobe, out_valid, out_last, busy, out_channel, out_data},
               64'd0);
      end else begin
         // activate: appears exactly two cycles after the decision, then holds until the burst ends
         if (pend == cyc) begin
            check("grant_channel", ch_activate, onehot(exp_ch));
            pend       = -1;
            burst      = 1;
            strobe_cnt = 0;
            model_last = exp_ch;
            grant_log.push_back(exp_ch);
         end else if (burst) begin
            if (ch_activate == 2'b00) begin
               check("burst_strobe_count", strobe_cnt, exp_size);
               burst     = 0;
               idle_from = cyc + 1;
            end else begin
               check("activate_stable", ch_activate, onehot(exp_ch));
            end
         end else begin
            check("activate_idle", ch_activate, 2'b00);
         end

         if (ch_strobe != 2'b00) begin
            check("strobe_target", {burst, ch_strobe}, {1'b1, onehot(exp_ch)});
            check("strobe_while_stalled", out_valid && !out_ready, 0);
            strobe_cnt++;
            strobe_pend = ch_strobe;
         end

         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_payload", {out_data, out_channel, out_last}, {prev_data, prev_ch, prev_last});
         end
         if (out_valid && out_ready) begin
            check("word_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
               w = expq.pop_front();
               check("out_data", out_data, w.d);
               check("out_channel", out_channel, w.ch);
               check("out_last", out_last, w.last);
               acc_log.push_back(out_data);
               acc_last_log.push_back(out_last);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_ch    = out_channel;
         prev_last  = out_last;

         check("busy", busy, out_valid || (ch_activate != 2'b00) || (pend >= 0) || (cyc < idle_from));

         // decision: idle, enabled, something ready -> next ready channel after the last grant
         if (!burst && pend < 0 && cyc >= idle_from && enable && ch_ready != 2'b00) begin
            for (int k = 1; k <= NUM_CH; k++) begin
               if (ch_ready[(model_last + k) % NUM_CH]) begin
                  exp_ch = (model_last + k) % NUM_CH;
                  break;
               end
            end
            exp_size = size_cfg[exp_ch];
            pend     = cyc + 2;
            for (int i = 0; i < exp_size; i++) begin
               w.d    = word_of(exp_ch, ptr[exp_ch] + 28'(i));
               w.ch   = exp_ch;
               w.last = (i == exp_size - 1);
               expq.push_back(w);
            end
         end
      end
   end

   // bench FIFOs advance their read pointer after the strobe edge
   always @(posedge clk) begin
      #1;
      for (int c = 0; c < NUM_CH; c++)
         if (strobe_pend[c]) ptr[c] = ptr[c] + 28'd1;
      strobe_pend = '0;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      ch_ready = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_grants(input int n, input int budget, input string name);
      int i;
      i = 0;
      while (grant_log.size() < n && i < budget) begin
         step();
         i++;
      end
      check(name, grant_log.size() >= n, 1);
   endtask

   initial begin
      logic [27:0] base;
      int          i;

      // 1: single burst of 4 on ch0
      step();
      step();
      rst = 1'b0;
      size_cfg[0] = 4;
      step();
      acc_log.delete();
      acc_last_log.delete();
      ch_ready = 2'b01;
      @(negedge clk) check("t1_act_cycle0", ch_activate, 2'b00);
      @(negedge clk) check("t1_act_cycle1", ch_activate, 2'b00);
      @(negedge clk) check("t1_act_rise", ch_activate, 2'b01);
      step();
      ch_ready = 2'b00;
      repeat (15) step();
      check("t1_word_count", acc_log.size(), 4);
      for (int k = 0; k < 4 && k < acc_log.size(); k++) begin
         check("t1_word", acc_log[k], 32'hA000_0000 + 32'(k));
         check("t1_last", acc_last_log[k], k == 3);
      end
      check("t1_idle_activate", ch_activate, 2'b00);
      check("t1_idle_busy", busy, 0);

      // 2: both ready -> 0,1,0
      do_reset();
      size_cfg[0] = 3;
      size_cfg[1] = 3;
      grant_log.delete();
      ch_ready = 2'b11;
      wait_grants(3, 100, "t2_grants_seen");
      ch_ready = 2'b00;
      if (grant_log.size() >= 3) begin
         check("t2_grant0", grant_log[0], 0);
         check("t2_grant1", grant_log[1], 1);
         check("t2_grant2", grant_log[2], 0);
      end
      repeat (20) step();

      // 3: backpressure 1,0,0,1 on a 5-word burst
      do_reset();
      size_cfg[0] = 5;
      base = ptr[0];
      acc_log.delete();
      grant_log.delete();
      ch_ready = 2'b01;
      for (i = 0; i < 40; i++) begin
         out_ready = (i % 4 == 0) || (i % 4 == 3);
         if (grant_log.size() != 0) ch_ready = 2'b00;
         step();
      end
      out_ready = 1'b1;
      check("t3_word_count", acc_log.size(), 5);
      for (int k = 0; k < 5 && k < acc_log.size(); k++)
         check("t3_word", acc_log[k], {4'hA, base + 28'(k)});

      // 4: zero-size burst on ch1, then ch0 is next
      size_cfg[1] = 0;
      acc_log.delete();
      grant_log.delete();
      ch_ready = 2'b10;
      wait_grants(1, 20, "t4_zero_grant_seen");
      ch_ready = 2'b00;
      repeat (6) step();
      if (grant_log.size() >= 1) check("t4_zero_grant_ch", grant_log[0], 1);
      check("t4_no_words", acc_log.size(), 0);
      size_cfg[0] = 2;
      ch_ready = 2'b11;
      wait_grants(2, 20, "t4_next_grant_seen");
      ch_ready = 2'b00;
      if (grant_log.size() >= 2) check("t4_next_grant_ch", grant_log[1], 0);
      repeat (15) step();

      // 5: async reset during word 2 of 6
      do_reset();
      size_cfg[0] = 6;
      acc_log.delete();
      grant_log.delete();
      ch_ready = 2'b01;
      i = 0;
      while (acc_log.size() < 2 && i < 30) begin
         @(negedge clk);
         i++;
      end
      check("t5_two_words", acc_log.size(), 2);
      check("t5_active_before", ch_activate, 2'b01);
      #2;
      rst = 1'b1;
      ch_ready = 2'b00;
      #1;
      check("t5_rst_immediate", {ch_activate, ch_strobe, out_valid}, 5'b0);
      step();
      step();
      rst = 1'b0;
      grant_log.delete();
      ch_ready = 2'b11;
      wait_grants(1, 20, "t5_regrant_seen");
      ch_ready = 2'b00;
      if (grant_log.size() >= 1) check("t5_first_after_rst", grant_log[0], 0);
      repeat (20) step();

      // 6: enable gating
      do_reset();
      size_cfg[0] = 3;
      size_cfg[1] = 3;
      grant_log.delete();
      acc_log.delete();
      enable = 1'b0;
      ch_ready = 2'b11;
      repeat (20) step();
      check("t6_no_grant_disabled", grant_log.size(), 0);
      check("t6_no_activate", ch_activate, 2'b00);
      enable = 1'b1;
      wait_grants(1, 20, "t6_grant_seen");
      enable = 1'b0;
      repeat (30) step();
      check("t6_single_grant", grant_log.size(), 1);
      check("t6_burst_words", acc_log.size(), 3);
      check("t6_idle_busy", busy, 0);
      ch_ready = 2'b00;
      enable = 1'b1;

      // random traffic
      do_reset();
      for (i = 0; i < 3000; i++) begin
         step();
         ch_ready  = 2'($urandom);
         enable    = ($urandom_range(9) != 0);
         out_ready = ($urandom_range(9) < 7);
         if ($urandom_range(7) == 0) size_cfg[$urandom_range(1)] = $urandom_range(6);
      end
      ch_ready  = 2'b00;
      enable    = 1'b1;
      out_ready = 1'b1;
      repeat (60) step();
      check("drain_queue_empty", expq.size(), 0);
      check("drain_no_burst", burst, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
